frame_scanout: RTL
==================

FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 SHALL have parameter ADDR_SIZE_BITS, default 24, SRAM address width.
REQ-002 SHALL have parameter WORD_SIZE_BYTES, default 3, bytes per pixel.
REQ-003 SHALL have parameter DATA_SIZE_WORDS, default 64, pixels per SRAM word.
REQ-004 SHALL have clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have scan_start, input, 1: one-cycle pulse that begins a scan; ignored unless IDLE.
REQ-007 SHALL have base_address, input, ADDR_SIZE_BITS: first SRAM word address, sampled on scan_start.
REQ-008 SHALL have num_words, input, 16: SRAM words to scan, sampled on scan_start.
REQ-009 SHALL have read_enable, output, 1: SRAM read strobe.
REQ-010 SHALL have address, output, ADDR_SIZE_BITS: SRAM word address.
REQ-011 SHALL have read_data, input, WORD_SIZE_BYTES*DATA_SIZE_WORDS*8: SRAM read word.
REQ-012 SHALL have pixel_out, output, WORD_SIZE_BYTES*8: current pixel.
REQ-013 SHALL have pixel_valid, output, 1, and pixel_ready, input, 1: valid/ready pixel handshake.
REQ-014 SHALL have busy, output, 1 (high when not IDLE), and scan_done, output, 1 (one-cycle pulse at scan end).

Function
REQ-015 SHALL implement states IDLE, READ, WAIT, SHIFT, DONE.
REQ-016 IDLE->READ on scan_start with num_words!=0; IDLE->DONE on scan_start with num_words==0.
REQ-017 READ: read_enable=1 for exactly one cycle, address=base_address+word_index (mod 2^ADDR_SIZE_BITS); ->WAIT.
REQ-018 WAIT: capture read_data into line register at end of this cycle (SRAM latency exactly 1 cycle); ->SHIFT.
REQ-019 SHIFT: pixel_valid=1; pixel_out = line[24*p+23:24*p], p = pixel index 0..DATA_SIZE_WORDS-1, pixel 0 at LSBs.
REQ-020 Transfer occurs only when pixel_valid&&pixel_ready; p increments per transfer; pixel_out SHALL stay stable while valid&&!ready.
REQ-021 After transfer of p=DATA_SIZE_WORDS-1: if word_index+1<num_words ->READ with word_index+1, else ->DONE.
REQ-022 DONE: scan_done=1 one cycle, ->IDLE; scan_start in DONE ignored.
REQ-023 read_enable SHALL be 0 outside READ (non-prefetch build); no write port exists.
REQ-024 Total transfers per scan SHALL equal num_words*DATA_SIZE_WORDS.

Reset
REQ-025 rst SHALL force IDLE, word_index=0, p=0, line register=0, read_enable=0, address=0, pixel_valid=0, pixel_out=0, busy=0, scan_done=0.
REQ-026 rst mid-scan SHALL abort immediately; no further reads or pixels; no scan_done pulse.

Configuration
REQ-027 Macro SCANOUT_PREFETCH_EN defined: second line register; next word read issued during first SHIFT cycle of current word; word-to-word SHIFT continuous with zero bubble cycles under constant pixel_ready.
REQ-028 SCANOUT_PREFETCH_EN undefined: single line register; exactly 2 bubble cycles (READ, WAIT) between words.

Structure
REQ-029 Package scanout_pkg SHALL hold state enum, PIXEL_BITS=WORD_SIZE_BYTES*8, WORD_BITS=PIXEL_BITS*DATA_SIZE_WORDS.
REQ-030 Sub-module pixel_serializer SHALL hold line register(s), pixel index and handshake; frame_scanout holds FSM and addressing.

Verification
REQ-031 base=0x000100, num_words=2, ready=1 -> reads at 0x000100 then 0x000101, 128 pixels in order, one scan_done.
REQ-032 num_words=0 -> no read_enable, scan_done one cycle after scan_start.
REQ-033 ready toggled 1010..., word pixels 0x000001..0x000040 -> output 0x000001..0x000040, each held stable until accepted.
REQ-034 base=0xFFFFFF, num_words=2 -> second address 0x000000.
REQ-035 rst asserted at pixel 10 of word 0 -> next cycle busy=0, pixel_valid=0, no scan_done; new scan_start runs normally.
REQ-036 SCANOUT_PREFETCH_EN, num_words=3, ready=1 -> 192 consecutive valid cycles with no gaps.

Source files
------------

// File: rtl/scanout_pkg.sv
// scanout_pkg: scan states, default geometry and index-width helper shared by the frame scanout block
package scanout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SHIFT,
        DONE
    } scan_state_e;

    localparam int ADDR_SIZE_BITS_DEF  = 24;
    localparam int WORD_SIZE_BYTES_DEF = 3;
    localparam int DATA_SIZE_WORDS_DEF = 64;
    localparam int PIXEL_BITS          = WORD_SIZE_BYTES_DEF * 8;
    localparam int WORD_BITS           = PIXEL_BITS * DATA_SIZE_WORDS_DEF;

    function automatic int idx_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_serializer.sv
// pixel_serializer: line register(s), pixel index and valid/ready handshake; SCANOUT_PREFETCH_EN adds a spare line register
module pixel_serializer
    import scanout_pkg::*;
#(
    parameter int WORD_SIZE_BYTES = WORD_SIZE_BYTES_DEF,
    parameter int DATA_SIZE_WORDS = DATA_SIZE_WORDS_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         load_i,
`ifdef SCANOUT_PREFETCH_EN
    input  logic                                         cap_i,
    input  logic                                         swap_i,
`endif
    input  logic                                         active_i,
    input  logic                                         ready_i,
    input  logic [WORD_SIZE_BYTES*8*DATA_SIZE_WORDS-1:0] data_i,
    output logic [WORD_SIZE_BYTES*8-1:0]                 pixel_o,
    output logic                                         valid_o,
    output logic                                         last_o
);

    localparam int PB = WORD_SIZE_BYTES * 8;
    localparam int PW = idx_bits(DATA_SIZE_WORDS);
    localparam logic [PW-1:0] P_LAST = PW'(DATA_SIZE_WORDS - 1);

    logic [DATA_SIZE_WORDS-1:0][PB-1:0] line_q, line_d;
    logic [PW-1:0] p_q, p_d;
    logic xfer;

    assign xfer    = active_i && ready_i;
    assign last_o  = xfer && p_q == P_LAST;
    assign valid_o = active_i;
    assign pixel_o = line_q[p_q];
    assign p_d     = load_i || last_o ? '0 : xfer ? p_q + 1'b1 : p_q;

`ifdef SCANOUT_PREFETCH_EN
    logic [DATA_SIZE_WORDS-1:0][PB-1:0] nxt_q, nxt_d;

    // next word parks in the spare register; on word change it becomes active, bypassed if it lands that same cycle
    always_comb begin
        nxt_d  = cap_i ? data_i : nxt_q;
        line_d = load_i ? data_i : swap_i ? (cap_i ? data_i : nxt_q) : line_q;
    end

    // spare line register
    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_q <= '0;
        end else begin
            nxt_q <= nxt_d;
        end
    end
`else
    // single line register reloaded only after each word's read returns
    always_comb begin
        line_d = load_i ? data_i : line_q;
    end
`endif

    // active line and pixel index
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            p_q    <= '0;
        end else begin
            line_q <= line_d;
            p_q    <= p_d;
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: reads SRAM words and streams their pixels out LSB-first; SCANOUT_PREFETCH_EN overlaps the next read with shifting
module frame_scanout
    import scanout_pkg::*;
#(
    parameter int ADDR_SIZE_BITS  = ADDR_SIZE_BITS_DEF,
    parameter int WORD_SIZE_BYTES = WORD_SIZE_BYTES_DEF,
    parameter int DATA_SIZE_WORDS = DATA_SIZE_WORDS_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         scan_start,
    input  logic [ADDR_SIZE_BITS-1:0]                    base_address,
    input  logic [15:0]                                  num_words,
    output logic                                         read_enable,
    output logic [ADDR_SIZE_BITS-1:0]                    address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic [WORD_SIZE_BYTES*8-1:0]                 pixel_out,
    output logic                                         pixel_valid,
    input  logic                                         pixel_ready,
    output logic                                         busy,
    output logic                                         scan_done
);

    scan_state_e state_q, state_d;
    logic [ADDR_SIZE_BITS-1:0] base_q, base_d;
    logic [15:0] num_q, num_d, idx_q, idx_d;
    logic load, last, more;

    assign more      = {1'b0, idx_q} + 17'd1 < {1'b0, num_q};
    assign busy      = state_q != IDLE;
    assign scan_done = state_q == DONE;

`ifdef SCANOUT_PREFETCH_EN
    logic pf_q, pf_d, rd_q, swap;

    assign address = base_q + ADDR_SIZE_BITS'(idx_q) + ADDR_SIZE_BITS'(state_q == SHIFT);
`else
    assign address = base_q + ADDR_SIZE_BITS'(idx_q);
`endif

    // scan sequencing: one read per word, then serialize until the word's last pixel is accepted
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        idx_d       = idx_q;
        read_enable = 1'b0;
        load        = 1'b0;
`ifdef SCANOUT_PREFETCH_EN
        pf_d        = pf_q;
        swap        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    base_d  = base_address;
                    num_d   = num_words;
                    idx_d   = '0;
                    state_d = num_words != 16'd0 ? READ : DONE;
                end
            end
            READ: begin
                read_enable = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                load    = 1'b1;
                state_d = SHIFT;
`ifdef SCANOUT_PREFETCH_EN
                pf_d    = 1'b0;
`endif
            end
            SHIFT: begin
`ifdef SCANOUT_PREFETCH_EN
                read_enable = !pf_q && more;
                pf_d        = pf_q || read_enable;
                if (last) begin
                    pf_d    = 1'b0;
                    swap    = more && !read_enable;
                    state_d = !more ? DONE : read_enable ? WAIT : SHIFT;
                    idx_d   = more ? idx_q + 16'd1 : idx_q;
                end
`else
                if (last) begin
                    state_d = more ? READ : DONE;
                    idx_d   = more ? idx_q + 16'd1 : idx_q;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latched scan context
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
`ifdef SCANOUT_PREFETCH_EN
            pf_q    <= 1'b0;
            rd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
`ifdef SCANOUT_PREFETCH_EN
            pf_q    <= pf_d;
            rd_q    <= read_enable;
`endif
        end
    end

    pixel_serializer #(
        .WORD_SIZE_BYTES(WORD_SIZE_BYTES),
        .DATA_SIZE_WORDS(DATA_SIZE_WORDS)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
`ifdef SCANOUT_PREFETCH_EN
        .cap_i   (rd_q && state_q == SHIFT),
        .swap_i  (swap),
`endif
        .active_i(state_q == SHIFT),
        .ready_i (pixel_ready),
        .data_i  (read_data),
        .pixel_o (pixel_out),
        .valid_o (pixel_valid),
        .last_o  (last)
    );

endmodule
